// File: rtl/prog_ctr_pkg.sv
// Shared types for the program-counter sequencer: FSM states and next-PC sources.
package prog_ctr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } pc_state_e;

    typedef enum logic [2:0] {
        SEL_HOLD = 3'd0,
        SEL_INC  = 3'd1,
        SEL_ABS  = 3'd2,
        SEL_REL  = 3'd3,
        SEL_CALL = 3'd4,
        SEL_RET  = 3'd5
    } pc_sel_e;

    // A redirect is any next-PC source that leaves the sequential flow.
    function automatic logic is_redirect(input pc_sel_e sel);
        return (sel == SEL_ABS) || (sel == SEL_REL) ||
               (sel == SEL_CALL) || (sel == SEL_RET);
    endfunction

endpackage

// File: rtl/prog_ctr_ret_stack.sv
// Return-address LIFO with zero-latency pop: data_o always shows the top entry.
module prog_ctr_ret_stack
    import prog_ctr_pkg::*;
#(
    parameter int L        = 10,
    parameter int RS_DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         srst_i,
    input  logic         clr_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [L-1:0] data_i,
    output logic [L-1:0] data_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = $clog2(RS_DEPTH);

    logic [L-1:0]  mem_q [RS_DEPTH];
    logic [AW:0]   cnt_q;
    logic [AW:0]   cnt_d;
    logic [AW-1:0] top_idx;
    logic [AW-1:0] wr_idx;

    assign wr_idx  = cnt_q[AW-1:0];
    assign top_idx = cnt_q[AW-1:0] - AW'(1);
    assign full_o  = (cnt_q == (AW+1)'(RS_DEPTH));
    assign empty_o = (cnt_q == '0);
    assign data_o  = mem_q[top_idx];

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (push_i && !full_o) begin
            cnt_d = cnt_q + (AW+1)'(1);
        end else if (pop_i && !empty_o) begin
            cnt_d = cnt_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Entries themselves need no reset; the count alone defines validity.
    generate
        for (genvar gi = 0; gi < RS_DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk_i) begin
                if (!srst_i && !clr_i && push_i && !full_o && wr_idx == AW'(gi)) begin
                    mem_q[gi] <= data_i;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/prog_ctr_seq.sv
// Program-counter sequencer: IDLE/RUN/DONE FSM, branches, call/return stack, sticky stack error.
// Optional taken-redirect counter output BranchCnt enabled by PROG_CTR_BRANCH_CNT_EN.
module prog_ctr_seq
    import prog_ctr_pkg::*;
#(
    parameter int L          = 10,
    parameter int RS_DEPTH   = 4,
    parameter int START_ADDR = 0,
    parameter int CW         = 8
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic         Stall,
    input  logic         Halt,
    input  logic         Cond,
    input  logic         BranchAbs,
    input  logic         BranchRel,
    input  logic         Call,
    input  logic         Ret,
    input  logic [L-1:0] Target,
    output logic [L-1:0] ProgCtr,
`ifdef PROG_CTR_BRANCH_CNT_EN
    output logic [CW-1:0] BranchCnt,
`endif
    output logic         Running,
    output logic         Done,
    output logic         StackErr
);

    localparam logic [L-1:0] START_PC = L'(START_ADDR);

    pc_state_e    state_q, state_d;
    pc_sel_e      sel;
    logic [L-1:0] pc_q, pc_d;
    logic         err_q, err_d;
    logic         stk_push, stk_pop, stk_clr;
    logic         stk_full, stk_empty;
    logic [L-1:0] stk_top;
    logic [L-1:0] pc_inc;

    assign pc_inc = pc_q + L'(1);

    prog_ctr_ret_stack #(
        .L        (L),
        .RS_DEPTH (RS_DEPTH)
    ) u_ret_stack (
        .clk_i   (Clk),
        .srst_i  (Reset),
        .clr_i   (stk_clr),
        .push_i  (stk_push),
        .pop_i   (stk_pop),
        .data_i  (pc_inc),
        .data_o  (stk_top),
        .full_o  (stk_full),
        .empty_o (stk_empty)
    );

    // FSM next state and next-PC source selection.
    always_comb begin
        state_d  = state_q;
        sel      = SEL_HOLD;
        err_d    = err_q;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        stk_clr  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (Start) begin
                    state_d = ST_RUN;
                    stk_clr = 1'b1;
                end
            end
            ST_RUN: begin
                if (Halt) begin
                    state_d = ST_DONE;
                end else if (Stall) begin
                    sel = SEL_HOLD;
                end else if (Ret) begin
                    if (stk_empty) begin
                        sel   = SEL_INC;
                        err_d = 1'b1;
                    end else begin
                        sel     = SEL_RET;
                        stk_pop = 1'b1;
                    end
                end else if (Call) begin
                    if (stk_full) begin
                        sel   = SEL_INC;
                        err_d = 1'b1;
                    end else begin
                        sel      = SEL_CALL;
                        stk_push = 1'b1;
                    end
                end else if (BranchAbs && Cond) begin
                    sel = SEL_ABS;
                end else if (BranchRel && Cond) begin
                    sel = SEL_REL;
                end else begin
                    sel = SEL_INC;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Next-PC mux; a start always restarts from the configured entry point.
    always_comb begin
        pc_d = pc_q;
        if (stk_clr) begin
            pc_d = START_PC;
        end else begin
            case (sel)
                SEL_INC:  pc_d = pc_inc;
                SEL_ABS:  pc_d = Target;
                SEL_REL:  pc_d = pc_q + Target;
                SEL_CALL: pc_d = Target;
                SEL_RET:  pc_d = stk_top;
                default:  pc_d = pc_q;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            pc_q    <= START_PC;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            err_q   <= err_d;
        end
    end

    assign ProgCtr  = pc_q;
    assign StackErr = err_q;
    assign Running  = (state_q == ST_RUN);
    assign Done     = (state_q == ST_DONE);

`ifdef PROG_CTR_BRANCH_CNT_EN
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (stk_clr) begin
            cnt_d = '0;
        end else if (is_redirect(sel) && cnt_q != '1) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign BranchCnt = cnt_q;
`endif

endmodule

// File: tb/tb_prog_ctr_seq.sv
// Scoreboard bench for prog_ctr_seq: a behavioural model queues expected outputs per edge.
module tb_prog_ctr_seq;

    localparam int L  = 10;
    localparam int RD = 4;
    localparam int CW = 2;

    logic         Clk = 1'b0;
    logic         Reset, Start, Stall, Halt, Cond, BranchAbs, BranchRel, Call, Ret;
    logic [L-1:0] Target;
    logic [L-1:0] ProgCtr;
    logic         Running, Done, StackErr;
`ifdef PROG_CTR_BRANCH_CNT_EN
    logic [CW-1:0] BranchCnt;
`endif

    prog_ctr_seq #(.L(L), .RS_DEPTH(RD), .START_ADDR(0), .CW(CW)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .Stall     (Stall),
        .Halt      (Halt),
        .Cond      (Cond),
        .BranchAbs (BranchAbs),
        .BranchRel (BranchRel),
        .Call      (Call),
        .Ret       (Ret),
        .Target    (Target),
        .ProgCtr   (ProgCtr),
`ifdef PROG_CTR_BRANCH_CNT_EN
        .BranchCnt (BranchCnt),
`endif
        .Running   (Running),
        .Done      (Done),
        .StackErr  (StackErr)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [L-1:0] pc;
        logic         run;
        logic         done;
        logic         err;
        int           cnt;
    } exp_t;

    exp_t exp_q[$];

    // Behavioural reference state
    int           m_state;   // 0 idle, 1 run, 2 done
    logic [L-1:0] m_pc;
    logic [L-1:0] m_stack[$];
    logic         m_err;
    int           m_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int step_no  = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL step %0d %s: got %0d expected %0d", step_no, tag, act, exp);
        end
    endtask

    function automatic void bump_cnt();
        if (m_cnt < (1 << CW) - 1) m_cnt++;
    endfunction

    function automatic void model_step();
        if (Reset) begin
            m_state = 0; m_pc = '0; m_stack.delete(); m_err = 1'b0; m_cnt = 0;
        end else if (m_state != 1) begin
            if (Start) begin
                m_state = 1; m_pc = '0; m_stack.delete(); m_cnt = 0;
            end
        end else if (Halt) begin
            m_state = 2;
        end else if (Stall) begin
            // nothing moves
        end else if (Ret) begin
            if (m_stack.size() == 0) begin
                m_pc = m_pc + 1'b1; m_err = 1'b1;
            end else begin
                m_pc = m_stack.pop_back(); bump_cnt();
            end
        end else if (Call) begin
            if (m_stack.size() == RD) begin
                m_pc = m_pc + 1'b1; m_err = 1'b1;
            end else begin
                m_stack.push_back(m_pc + 1'b1); m_pc = Target; bump_cnt();
            end
        end else if (BranchAbs && Cond) begin
            m_pc = Target; bump_cnt();
        end else if (BranchRel && Cond) begin
            m_pc = m_pc + Target; bump_cnt();
        end else begin
            m_pc = m_pc + 1'b1;
        end
    endfunction

    task automatic tick();
        exp_t e;
        model_step();
        e.pc = m_pc; e.run = (m_state == 1); e.done = (m_state == 2);
        e.err = m_err; e.cnt = m_cnt;
        exp_q.push_back(e);
        @(posedge Clk);
        #1;
        step_no++;
        e = exp_q.pop_front();
        check("pc", 32'(ProgCtr), 32'(e.pc));
        check("running", 32'(Running), 32'(e.run));
        check("done", 32'(Done), 32'(e.done));
        check("stackerr", 32'(StackErr), 32'(e.err));
`ifdef PROG_CTR_BRANCH_CNT_EN
        check("branchcnt", 32'(BranchCnt), 32'(e.cnt));
`endif
        $display("step %0d pc=%0d run=%0b done=%0b err=%0b", step_no, ProgCtr, Running, Done, StackErr);
    endtask

    // One instruction cycle: set every control input, then advance one edge.
    task automatic op(input bit rst, st, stl, hlt, cnd, ba, br, cl, rt, input logic [L-1:0] tgt);
        Reset = rst; Start = st; Stall = stl; Halt = hlt; Cond = cnd;
        BranchAbs = ba; BranchRel = br; Call = cl; Ret = rt; Target = tgt;
        tick();
    endtask

    task automatic nop();           op(0,0,0,0,0,0,0,0,0,'0); endtask
    task automatic start();         op(0,1,0,0,0,0,0,0,0,'0); endtask
    task automatic rst();           op(1,0,0,0,0,0,0,0,0,'0); endtask
    task automatic jabs(input logic [L-1:0] t); op(0,0,0,0,1,1,0,0,0,t); endtask
    task automatic call(input logic [L-1:0] t); op(0,0,0,0,0,0,0,1,0,t); endtask
    task automatic ret();           op(0,0,0,0,0,0,0,0,1,'0); endtask

    initial begin
        Reset = 1; Start = 0; Stall = 0; Halt = 0; Cond = 0;
        BranchAbs = 0; BranchRel = 0; Call = 0; Ret = 0; Target = '0;

        rst(); rst();
        start();
        repeat (5) nop();

        // Reset mid-run at PC=3
        rst(); start(); repeat (3) nop(); rst();

        // Branches and wrap
        start();
        jabs(10);
        op(0,0,0,0,1,0,1,0,0,10'h3FC);   // 10 -> 6
        jabs(10);
        op(0,0,0,0,0,0,1,0,0,10'h3FC);   // Cond=0 -> 11
        op(0,0,0,0,0,1,0,0,0,10'd500);   // BranchAbs Cond=0 -> 12
        jabs(1023);
        nop();                           // wraps to 0

        // Call/return
        jabs(20);
        call(100);
        repeat (5) nop();
        ret();                           // -> 21
        call(200); call(300); call(400); call(500);
        call(600);                       // full -> +1, error
        repeat (4) ret();
        ret();                           // empty -> +1
        nop();

        // Halt overrides Call and Stall; DONE ignores controls
        jabs(50);
        call(7);
        op(0,0,1,1,0,0,0,1,0,10'd99);
        op(0,0,0,0,1,1,0,1,1,10'd77);
        nop();
        start();
        ret();                           // stack was cleared by start
        op(0,0,1,0,1,1,0,0,0,10'd300);   // stalled branch
        op(0,1,0,0,0,0,0,0,0,'0);        // Start ignored in RUN
        rst();

        // Randomised traffic against the model
        start();
        for (int i = 0; i < 300; i++) begin
            op($urandom_range(0, 60) == 0, $urandom_range(0, 10) == 0,
               $urandom_range(0, 6) == 0, $urandom_range(0, 25) == 0,
               1'($urandom), $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
               $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
               L'($urandom));
        end

        if (exp_q.size() != 0) check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
